// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - video/DMA arbiter for an asynchronous byte-wide SRAM
// Video has priority; a starvation counter forces a DMA grant after STARVE_LIMIT video grants.
module vram_arb #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        v_clk,
   input  logic        v_rst_n,
   input  logic        vid_req,
   input  logic [16:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_rdata,
   output logic        vid_rvalid,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [16:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic        dma_rvalid,
   output logic [16:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_data_oe,
   input  logic [7:0]  mem_rdata,
   output logic        mem_oe_n,
   output logic        mem_we_n
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          own_vid_q, own_vid_d;
   logic          we_q, we_d;
   logic [16:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          vid_ack_q, vid_ack_d;
   logic          dma_ack_q, dma_ack_d;
   logic          vid_rvalid_q, vid_rvalid_d;
   logic          dma_rvalid_q, dma_rvalid_d;
   logic [7:0]    vid_rdata_q, vid_rdata_d;
   logic [7:0]    dma_rdata_q, dma_rdata_d;

   logic          starved;
   logic          grant_vid;
   logic          grant_dma;

   assign starved   = (cnt_q == CW'(STARVE_LIMIT));
   assign grant_vid = vid_req && !(dma_req && starved);
   assign grant_dma = dma_req && !grant_vid;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      own_vid_d    = own_vid_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      vid_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;
      vid_rvalid_d = 1'b0;
      dma_rvalid_d = 1'b0;
      vid_rdata_d  = vid_rdata_q;
      dma_rdata_d  = dma_rdata_q;

      case (state_q)
         S_SETUP: begin
            state_d = S_STROBE;
         end
         S_IDLE, S_STROBE: begin
            // Read data is sampled as the strobe ends, while mem_oe_n is still low.
            if (state_q == S_STROBE && !we_q) begin
               if (own_vid_q) begin
                  vid_rdata_d  = mem_rdata;
                  vid_rvalid_d = 1'b1;
               end else begin
                  dma_rdata_d  = mem_rdata;
                  dma_rvalid_d = 1'b1;
               end
            end
            if (grant_vid) begin
               state_d   = S_SETUP;
               own_vid_d = 1'b1;
               we_d      = 1'b0;
               addr_d    = vid_addr;
               vid_ack_d = 1'b1;
               cnt_d     = dma_req ? cnt_q + CW'(1) : '0;
            end else if (grant_dma) begin
               state_d   = S_SETUP;
               own_vid_d = 1'b0;
               we_d      = dma_we;
               addr_d    = dma_addr;
               wdata_d   = dma_wdata;
               dma_ack_d = 1'b1;
               cnt_d     = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge v_clk or negedge v_rst_n) begin
      if (!v_rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         own_vid_q    <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         vid_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         vid_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         vid_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         own_vid_q    <= own_vid_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         vid_ack_q    <= vid_ack_d;
         dma_ack_q    <= dma_ack_d;
         vid_rvalid_q <= vid_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
         vid_rdata_q  <= vid_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   // Strobes decode straight from the state flop so an async reset releases the bus at once.
   assign mem_oe_n    = !((state_q == S_SETUP || state_q == S_STROBE) && !we_q);
   assign mem_we_n    = !((state_q == S_STROBE) && we_q);
   assign mem_data_oe = (state_q == S_SETUP || state_q == S_STROBE) && we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;

   assign vid_ack    = vid_ack_q;
   assign dma_ack    = dma_ack_q;
   assign vid_rvalid = vid_rvalid_q;
   assign dma_rvalid = dma_rvalid_q;
   assign vid_rdata  = vid_rdata_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - directed self-checking bench for vram_arb
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vram_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_req;
   logic [16:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_rdata;
   logic        vid_rvalid;
   logic        dma_req;
   logic        dma_we;
   logic [16:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic [16:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_data_oe;
   logic [7:0]  mem_rdata;
   logic        mem_oe_n;
   logic        mem_we_n;

   int total = 0;
   int bad   = 0;

   logic [7:0] sram [0:131071] = '{default: 8'h00};

   int gv[$];
   int gt[$];
   int we_lo, doe_hi, oe_lo, both_ack;
   int drv_n, drv_cyc, vrv_n;
   logic [7:0] drv_data, vrv_data;

   vram_arb #(.STARVE_LIMIT(4)) dut (
      .v_clk(clk), .v_rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
      .mem_rdata(mem_rdata), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
   );

   always #5 clk = ~clk;

   // SRAM model: two fixed locations, everything else written by the DUT.
   always @(posedge clk) if (!mem_we_n && mem_data_oe) sram[mem_addr] <= mem_wdata;
   assign mem_rdata = (mem_addr == 17'h01010) ? 8'h5A :
                      (mem_addr == 17'h00077) ? 8'h3C : sram[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n, input bit autodrop);
      gv.delete(); gt.delete();
      we_lo = 0; doe_hi = 0; oe_lo = 0; both_ack = 0;
      drv_n = 0; drv_cyc = 0; vrv_n = 0; drv_data = '0; vrv_data = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (vid_ack && dma_ack) both_ack++;
         if (vid_ack) begin gv.push_back(0); gt.push_back(k); if (autodrop) vid_req = 1'b0; end
         if (dma_ack) begin gv.push_back(1); gt.push_back(k); if (autodrop) dma_req = 1'b0; end
         if (!mem_we_n) we_lo++;
         if (mem_data_oe) doe_hi++;
         if (!mem_oe_n) oe_lo++;
         if (dma_rvalid) begin drv_n++; drv_cyc = k; drv_data = dma_rdata; end
         if (vid_rvalid) begin vrv_n++; vrv_data = vid_rdata; end
      end
   endtask

   initial begin
      rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_oe_n", mem_oe_n, 1);
      chk("rst_we_n", mem_we_n, 1);
      chk("rst_data_oe", mem_data_oe, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_acks", {vid_ack, dma_ack, vid_rvalid, dma_rvalid}, 0);
      chk("rst_rdata", {vid_rdata, dma_rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // DMA write alone
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h03030; dma_wdata = 8'hA5;
      run(8, 1);
      chk("wr_grants", gv.size(), 1);
      chk("wr_ack_cyc", gt[0], 1);
      chk("wr_we_lo", we_lo, 1);
      chk("wr_doe_hi", doe_hi, 2);
      chk("wr_oe_lo", oe_lo, 0);
      chk("wr_no_rvalid", drv_n, 0);
      chk("wr_mem", sram[17'h03030], 8'hA5);

      // DMA read alone
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h01010;
      run(8, 1);
      chk("rd_ack_cyc", gt[0], 1);
      chk("rd_rvalid_n", drv_n, 1);
      chk("rd_rvalid_cyc", drv_cyc, 3);
      chk("rd_data", drv_data, 8'h5A);
      chk("rd_oe_lo", oe_lo, 2);
      chk("rd_we_lo", we_lo, 0);
      chk("rd_hold", dma_rdata, 8'h5A);

      // simultaneous single requests, counter at zero
      vid_req = 1'b1; vid_addr = 17'h00077;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h03030;
      run(10, 1);
      chk("sim_grants", gv.size(), 2);
      chk("sim_first", gv[0], 0);
      chk("sim_first_cyc", gt[0], 1);
      chk("sim_second", gv[1], 1);
      chk("sim_second_cyc", gt[1], 3);
      chk("sim_both", both_ack, 0);
      chk("sim_vdata", vrv_data, 8'h3C);
      chk("sim_ddata", drv_data, 8'hA5);

      // both held: 4 video, 1 DMA, back-to-back
      vid_req = 1'b1; vid_addr = 17'h00077;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h01010;
      run(24, 0);
      chk("cont_grants", gv.size(), 12);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("cont_who%0d", i), gv[i], (i % 5 == 4) ? 1 : 0);
         chk($sformatf("cont_cyc%0d", i), gt[i], 1 + 2 * i);
      end
      chk("cont_both", both_ack, 0);
      chk("cont_vrv", vrv_n, 9);
      chk("cont_drv", drv_n, 2);
      chk("cont_vdata", vrv_data, 8'h3C);
      chk("cont_ddata", drv_data, 8'h5A);
      vid_req = 1'b0; dma_req = 1'b0;
      run(6, 0);
      chk("drain_grants", gv.size(), 0);

      // reset during STROBE of a write
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h00100; dma_wdata = 8'hEE;
      run(2, 1);
      chk("rw_ack", gt[0], 1);
      chk("rw_we_lo", mem_we_n, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_we_n", mem_we_n, 1);
      chk("rw_doe", mem_data_oe, 0);
      chk("rw_addr", mem_addr, 0);
      chk("rw_drdata", dma_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(6, 1);
      chk("rw_no_ack", gv.size(), 0);
      chk("rw_no_rvalid", drv_n, 0);
      chk("rw_no_we", we_lo, 0);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h00100;
      run(6, 1);
      chk("rw_readback", drv_data, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
